// File: rtl/noc_vc_credit_link.sv
// noc_vc_credit_link
//   Credit-based multi-VC output link. Buffers flits per virtual channel,
//   grants one eligible VC per cycle round-robin, and drives a registered
//   send interface followed by NUM_PIPELINE extra stages. Downstream credits
//   come back on credit_in through an equally deep register chain.
//
//   Optional feature macro: NOC_LINK_STATS_EN enables the per-VC sent-flit
//   and credit-stall counters. Without it, stat_* are tied to zero.
//
//   Ports:
//     clk_noc, rst_noc_sync          clock, synchronous active-high reset
//     in_valid/in_ready              per-VC flit handshake
//     in_data/in_dest/in_is_tail     per-VC flit payload
//     data_out/dest_out/is_tail_out  link flit fields
//     vc_out/send_out                link VC index and flit valid
//     credit_in                      per-VC credit return, one pulse per slot
//     credit_err                     sticky credit overflow flag
//     stat_flits/stat_stalls         per-VC 16-bit statistics counters
module noc_vc_credit_link #(
    parameter int unsigned NUM_VCS            = 2,
    parameter int unsigned FLIT_WIDTH         = 32,
    parameter int unsigned DEST_WIDTH         = 6,
    parameter int unsigned VC_BUFFER_DEPTH    = 4,
    parameter int unsigned DOWNSTREAM_CREDITS = 1,
    parameter int unsigned NUM_PIPELINE       = 0,
    parameter int unsigned VC_WIDTH           = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic                                clk_noc,
    input  logic                                rst_noc_sync,
    input  logic [NUM_VCS-1:0]                  in_valid,
    output logic [NUM_VCS-1:0]                  in_ready,
    input  logic [NUM_VCS-1:0][FLIT_WIDTH-1:0]  in_data,
    input  logic [NUM_VCS-1:0][DEST_WIDTH-1:0]  in_dest,
    input  logic [NUM_VCS-1:0]                  in_is_tail,
    output logic [FLIT_WIDTH-1:0]               data_out,
    output logic [DEST_WIDTH-1:0]               dest_out,
    output logic                                is_tail_out,
    output logic [VC_WIDTH-1:0]                 vc_out,
    output logic                                send_out,
    input  logic [NUM_VCS-1:0]                  credit_in,
    output logic                                credit_err,
    output logic [NUM_VCS-1:0][15:0]            stat_flits,
    output logic [NUM_VCS-1:0][15:0]            stat_stalls
);
    localparam int unsigned AW        = $clog2(VC_BUFFER_DEPTH);
    localparam logic [3:0]  CRED_INIT = 4'(DOWNSTREAM_CREDITS);
    localparam logic [AW:0] PTR_ONE   = 1;

    typedef struct packed {
        logic                  tail;
        logic [DEST_WIDTH-1:0] dest;
        logic [FLIT_WIDTH-1:0] data;
    } entry_t;

    typedef struct packed {
        logic                send;
        logic [VC_WIDTH-1:0] vc;
        entry_t              e;
    } stage_t;

    entry_t              r_mem  [NUM_VCS][VC_BUFFER_DEPTH];
    logic [AW:0]         r_wptr [NUM_VCS];
    logic [AW:0]         r_rptr [NUM_VCS];
    logic [3:0]          r_cred [NUM_VCS];
    logic [VC_WIDTH-1:0] r_rr;
    logic                r_err;
    stage_t              r_out;

    logic [NUM_VCS-1:0]  w_empty;
    logic [NUM_VCS-1:0]  w_full;
    logic [NUM_VCS-1:0]  w_elig;
    logic [NUM_VCS-1:0]  w_wr;
    logic [NUM_VCS-1:0]  w_cred_dly;
    logic [NUM_VCS-1:0]  w_gnt_oh;
    logic                w_gnt;
    logic [VC_WIDTH-1:0] w_gnt_vc;
    entry_t              w_head;
    stage_t              w_last;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            w_empty[v]  = (r_wptr[v] == r_rptr[v]);
            w_full[v]   = (r_wptr[v][AW] != r_rptr[v][AW]) &&
                          (r_wptr[v][AW-1:0] == r_rptr[v][AW-1:0]);
            w_elig[v]   = !w_empty[v] && (r_cred[v] != '0);
            in_ready[v] = !w_full[v] && !rst_noc_sync;
            w_wr[v]     = in_valid[v] && in_ready[v];
        end
    end

    // Round-robin: scan offsets 0..NUM_VCS-1 from r_rr, first eligible wins.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_vc = '0;
        w_gnt_oh = '0;
        w_head   = '0;
        for (int unsigned i = 0; i < NUM_VCS; i++) begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                if (!w_gnt && w_elig[v] && (v == (32'(r_rr) + i) % NUM_VCS)) begin
                    w_gnt       = 1'b1;
                    w_gnt_vc    = VC_WIDTH'(v);
                    w_gnt_oh[v] = 1'b1;
                    w_head      = r_mem[v][r_rptr[v][AW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                r_wptr[v] <= '0;
                r_rptr[v] <= '0;
                r_cred[v] <= CRED_INIT;
            end
            r_rr  <= '0;
            r_err <= 1'b0;
            r_out <= '0;
        end else begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                if (w_wr[v]) begin
                    r_mem[v][r_wptr[v][AW-1:0]] <= {in_is_tail[v], in_dest[v], in_data[v]};
                    r_wptr[v] <= r_wptr[v] + PTR_ONE;
                end
                if (w_gnt_oh[v]) begin
                    r_rptr[v] <= r_rptr[v] + PTR_ONE;
                end
                // Grant and returning credit in the same cycle cancel out.
                if (w_gnt_oh[v] && !w_cred_dly[v]) begin
                    r_cred[v] <= r_cred[v] - 4'd1;
                end else if (!w_gnt_oh[v] && w_cred_dly[v]) begin
                    if (r_cred[v] == CRED_INIT) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cred[v] <= r_cred[v] + 4'd1;
                    end
                end
            end
            if (w_gnt) begin
                r_out.send <= 1'b1;
                r_out.vc   <= w_gnt_vc;
                r_out.e    <= w_head;
                r_rr       <= VC_WIDTH'((32'(w_gnt_vc) + 32'd1) % NUM_VCS);
            end else begin
                r_out.send <= 1'b0;
            end
        end
    end

    generate
        if (NUM_PIPELINE == 0) begin : g_no_pipe
            assign w_cred_dly = credit_in;
            assign w_last     = r_out;
        end else begin : g_pipe
            logic [NUM_VCS-1:0] r_cpipe [NUM_PIPELINE];
            stage_t             r_fpipe [NUM_PIPELINE];

            // Payload fields only advance behind a valid flit; otherwise they hold.
            always_ff @(posedge clk_noc) begin
                if (rst_noc_sync) begin
                    for (int unsigned k = 0; k < NUM_PIPELINE; k++) begin
                        r_cpipe[k] <= '0;
                        r_fpipe[k] <= '0;
                    end
                end else begin
                    r_cpipe[0] <= credit_in;
                    if (r_out.send) r_fpipe[0] <= r_out;
                    else            r_fpipe[0].send <= 1'b0;
                    for (int unsigned k = 1; k < NUM_PIPELINE; k++) begin
                        r_cpipe[k] <= r_cpipe[k-1];
                        if (r_fpipe[k-1].send) r_fpipe[k] <= r_fpipe[k-1];
                        else                   r_fpipe[k].send <= 1'b0;
                    end
                end
            end

            assign w_cred_dly = r_cpipe[NUM_PIPELINE-1];
            assign w_last     = r_fpipe[NUM_PIPELINE-1];
        end
    endgenerate

    assign send_out    = w_last.send;
    assign vc_out      = w_last.vc;
    assign is_tail_out = w_last.e.tail;
    assign dest_out    = w_last.e.dest;
    assign data_out    = w_last.e.data;
    assign credit_err  = r_err;

`ifdef NOC_LINK_STATS_EN
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            stat_flits  <= '0;
            stat_stalls <= '0;
        end else begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                if (w_gnt_oh[v]) begin
                    stat_flits[v] <= stat_flits[v] + 16'd1;
                end
                if (!w_empty[v] && (r_cred[v] == '0)) begin
                    stat_stalls[v] <= stat_stalls[v] + 16'd1;
                end
            end
        end
    end
`else
    assign stat_flits  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_noc_vc_credit_link.sv
module tb_noc_vc_credit_link;
    localparam int NV    = 4;
    localparam int FW    = 32;
    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int DC    = 2;
    localparam int NP    = 1;
    localparam int VW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NV-1:0]         in_valid   = '0;
    logic [NV-1:0]         in_ready;
    logic [NV-1:0][FW-1:0] in_data    = '0;
    logic [NV-1:0][DW-1:0] in_dest    = '0;
    logic [NV-1:0]         in_is_tail = '0;
    logic [FW-1:0]         data_out;
    logic [DW-1:0]         dest_out;
    logic                  is_tail_out;
    logic [VW-1:0]         vc_out;
    logic                  send_out;
    logic [NV-1:0]         credit_in  = '0;
    logic                  credit_err;
    logic [NV-1:0][15:0]   stat_flits;
    logic [NV-1:0][15:0]   stat_stalls;

    int checks   = 0;
    int failures = 0;

    noc_vc_credit_link #(
        .NUM_VCS(NV), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .VC_BUFFER_DEPTH(DEPTH),
        .DOWNSTREAM_CREDITS(DC), .NUM_PIPELINE(NP), .VC_WIDTH(VW)
    ) dut (
        .clk_noc(clk), .rst_noc_sync(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dest(in_dest), .in_is_tail(in_is_tail),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .vc_out(vc_out), .send_out(send_out), .credit_in(credit_in),
        .credit_err(credit_err), .stat_flits(stat_flits), .stat_stalls(stat_stalls)
    );

    always #5 clk = ~clk;

    logic [46:0] dut_vec;
    assign dut_vec = {send_out, vc_out, is_tail_out, dest_out, data_out, credit_err, in_ready};

    // Reference model: per-VC queues, integer credit counts, delay lines as queues.
    typedef struct packed { logic tail; logic [DW-1:0] dest; logic [FW-1:0] data; } flit_t;
    typedef struct packed { logic send; logic [VW-1:0] vc; flit_t f; } out_t;

    flit_t         mq [NV][$];
    int            m_cred [NV];
    int            m_rr;
    bit            m_err;
    logic [NV-1:0] m_chist [$];
    out_t          m_stage [NP+1];
    int            m_sflits [NV];
    int            m_sstalls [NV];

    always @(posedge clk) begin : p_model
        int g;
        logic [NV-1:0] dly;
        logic [NV-1:0] rdy;
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                mq[v].delete();
                m_cred[v] = DC;
                m_sflits[v] = 0;
                m_sstalls[v] = 0;
            end
            m_rr = 0;
            m_err = 1'b0;
            m_chist.delete();
            for (int k = 0; k <= NP; k++) m_stage[k] = '0;
        end else begin
            for (int v = 0; v < NV; v++) rdy[v] = (mq[v].size() < DEPTH);
            m_chist.push_back(credit_in);
            dly = '0;
            if (m_chist.size() > NP) dly = m_chist.pop_front();
            g = -1;
            for (int i = 0; i < NV; i++) begin
                int v;
                v = (m_rr + i) % NV;
                if (g < 0 && mq[v].size() > 0 && m_cred[v] > 0) g = v;
            end
            for (int v = 0; v < NV; v++) begin
                if (mq[v].size() > 0 && m_cred[v] == 0) m_sstalls[v] = (m_sstalls[v] + 1) % 65536;
                if (g == v && !dly[v]) m_cred[v] = m_cred[v] - 1;
                else if (g != v && dly[v]) begin
                    if (m_cred[v] == DC) m_err = 1'b1;
                    else m_cred[v] = m_cred[v] + 1;
                end
            end
            for (int k = NP; k >= 1; k--) begin
                if (m_stage[k-1].send) m_stage[k] = m_stage[k-1];
                else m_stage[k].send = 1'b0;
            end
            if (g >= 0) begin
                m_stage[0].send = 1'b1;
                m_stage[0].vc = VW'(g);
                m_stage[0].f = mq[g].pop_front();
                m_sflits[g] = (m_sflits[g] + 1) % 65536;
                m_rr = (g + 1) % NV;
            end else begin
                m_stage[0].send = 1'b0;
            end
            for (int v = 0; v < NV; v++)
                if (in_valid[v] && rdy[v]) mq[v].push_back({in_is_tail[v], in_dest[v], in_data[v]});
        end
    end

    function automatic logic [46:0] model_vec();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = !rst && (mq[v].size() < DEPTH);
        return {m_stage[NP], m_err, r};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = '0;
        credit_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = '0;
        credit_in = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== '0 || stat_flits !== '0 || stat_stalls !== '0) begin
                failures++;
                $display("FAIL reset_outputs got=%h exp=0", dut_vec);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== '1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1111", in_ready);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL reset_model got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_single_flit();
        int lat = 0;
        int sends = 0;
        logic [VW-1:0] got_vc = '0;
        logic [FW-1:0] got_data = '0;
        do_reset();
        in_valid[1] = 1'b1;
        in_data[1] = 32'hA5A5A5A5;
        in_dest[1] = 6'h15;
        in_is_tail[1] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            in_valid[1] = 1'b0;
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL single_model c=%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            if (lat == 0 && send_out === 1'b1) begin
                lat = c;
                got_vc = vc_out;
                got_data = data_out;
            end
        end
        checks++;
        if (lat != 2 + NP) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=%0d", lat, 2 + NP);
        end
        checks++;
        if (got_vc !== 2'd1 || got_data !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL single_fields got=vc%0d/%h exp=vc1/a5a5a5a5", got_vc, got_data);
        end
        // Two more VC1 flits: the first uses the last credit, the second waits.
        for (int k = 0; k < 2; k++) begin
            in_valid[1] = 1'b1;
            in_data[1] = $urandom;
            in_is_tail[1] = 1'(k);
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL held_model k=%0d got=%h exp=%h", k, dut_vec, model_vec());
            end
            if (send_out === 1'b1) sends++;
        end
        in_valid[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL held_model c=%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            if (send_out === 1'b1) sends++;
        end
        checks++;
        if (sends != 1) begin
            failures++;
            $display("FAIL held_sends got=%0d exp=1", sends);
        end
        credit_in[1] = 1'b1;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            credit_in[1] = 1'b0;
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL credit_model c=%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            if (lat == 0 && send_out === 1'b1) lat = c;
        end
        checks++;
        if (lat != 2 + 2 * NP) begin
            failures++;
            $display("FAIL credit_latency got=%0d exp=%0d", lat, 2 + 2 * NP);
        end
    endtask

    task automatic test_round_robin();
        int seq[$];
        do_reset();
        for (int c = 0; c < 24; c++) begin
            in_valid = (c < DC + 1) ? '1 : '0;
            for (int v = 0; v < NV; v++) begin
                in_data[v] = {8'(v), 24'($urandom)};
                in_dest[v] = 6'($urandom);
                in_is_tail[v] = 1'($urandom);
            end
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL rr_model c=%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            if (send_out === 1'b1) seq.push_back(int'(vc_out));
        end
        in_valid = '0;
        checks++;
        if (seq.size() != DC * NV) begin
            failures++;
            $display("FAIL rr_count got=%0d exp=%0d", seq.size(), DC * NV);
        end
        for (int i = 0; i < seq.size() && i < DC * NV; i++) begin
            checks++;
            if (seq[i] != i % NV) begin
                failures++;
                $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, seq[i], i % NV);
            end
        end
    endtask

    task automatic test_grant_and_credit();
        int sends = 0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            in_valid[0] = (k < 12);
            in_data[0] = $urandom;
            credit_in[0] = (k + NP >= 1) && (k + NP <= 10);
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL gc_model k=%0d got=%h exp=%h", k, dut_vec, model_vec());
            end
            if (send_out === 1'b1) sends++;
        end
        in_valid = '0;
        credit_in = '0;
        checks++;
        if (sends != 12 || credit_err !== 1'b0) begin
            failures++;
            $display("FAIL gc_sends got=%0d/err%b exp=12/err0", sends, credit_err);
        end
    endtask

    task automatic test_credit_overflow();
        int sends = 0;
        do_reset();
        credit_in[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            credit_in[0] = 1'b0;
            checks++;
            if (credit_err !== 1'(c >= NP + 1)) begin
                failures++;
                $display("FAIL ovf_flag c=%0d got=%b exp=%b", c, credit_err, c >= NP + 1);
            end
        end
        // Counter must have stayed at the reset credit count.
        for (int c = 0; c < 16; c++) begin
            in_valid[0] = (c < DC + 1);
            in_data[0] = $urandom;
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL ovf_model c=%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            if (send_out === 1'b1) sends++;
        end
        in_valid = '0;
        checks++;
        if (sends != DC || credit_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sends got=%0d/err%b exp=%0d/err1", sends, credit_err, DC);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (credit_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", credit_err);
        end
    endtask

    task automatic test_fifo_full();
        int sends = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            in_valid[0] = (c < DC);
            in_data[0] = $urandom;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready[0] !== 1'(i < DEPTH)) begin
                failures++;
                $display("FAIL full_ready i=%0d got=%b exp=%b", i, in_ready[0], i < DEPTH);
            end
            in_valid[0] = 1'b1;
            in_data[0] = 32'h100 + 32'(i);
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL full_model i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        in_valid = '0;
        for (int c = 0; c < 24; c++) begin
            credit_in[0] = (c % 4 == 0) && (c < 16);
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL drain_model c=%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            if (send_out === 1'b1) sends++;
        end
        credit_in = '0;
        checks++;
        if (sends != DEPTH) begin
            failures++;
            $display("FAIL drain_sends got=%0d exp=%0d", sends, DEPTH);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            in_valid = 4'($urandom);
            for (int v = 0; v < NV; v++) in_data[v] = $urandom;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec !== '0 || stat_flits !== '0 || stat_stalls !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=0", dut_vec);
        end
        in_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== '1) begin
            failures++;
            $display("FAIL midreset_ready got=%b exp=1111", in_ready);
        end
    endtask

    task automatic test_stats();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            in_valid[2] = (c < 3);
            in_data[2] = $urandom;
            credit_in[2] = (c == 10);
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL stats_model c=%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
        end
        in_valid = '0;
        credit_in = '0;
`ifdef NOC_LINK_STATS_EN
        checks++;
        if (stat_flits[2] !== 16'd3) begin
            failures++;
            $display("FAIL stats_flits2 got=%0d exp=3", stat_flits[2]);
        end
        for (int v = 0; v < NV; v++) begin
            checks++;
            if (stat_flits[v] !== 16'(m_sflits[v]) || stat_stalls[v] !== 16'(m_sstalls[v])) begin
                failures++;
                $display("FAIL stats_vc%0d got=%0d/%0d exp=%0d/%0d", v, stat_flits[v], stat_stalls[v], m_sflits[v], m_sstalls[v]);
            end
        end
`else
        checks++;
        if (stat_flits !== '0 || stat_stalls !== '0) begin
            failures++;
            $display("FAIL stats_tied got=%h/%h exp=0", stat_flits, stat_stalls);
        end
`endif
    endtask

    task automatic test_random();
        int outst [NV];
        do_reset();
        for (int v = 0; v < NV; v++) outst[v] = 0;
        for (int c = 0; c < 460; c++) begin
            for (int v = 0; v < NV; v++) begin
                in_valid[v] = (c < 400) && ($urandom_range(0, 1) == 1);
                in_data[v] = $urandom;
                in_dest[v] = 6'($urandom);
                in_is_tail[v] = 1'($urandom);
                credit_in[v] = 1'b0;
                if (outst[v] > 0 && (c >= 400 || $urandom_range(0, 9) < 3)) begin
                    credit_in[v] = 1'b1;
                    outst[v]--;
                end
            end
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_vec, model_vec());
            end
            if (send_out === 1'b1) outst[vc_out]++;
        end
        in_valid = '0;
        credit_in = '0;
`ifdef NOC_LINK_STATS_EN
        for (int v = 0; v < NV; v++) begin
            checks++;
            if (stat_flits[v] !== 16'(m_sflits[v]) || stat_stalls[v] !== 16'(m_sstalls[v])) begin
                failures++;
                $display("FAIL random_stats vc%0d got=%0d/%0d exp=%0d/%0d", v, stat_flits[v], stat_stalls[v], m_sflits[v], m_sstalls[v]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_round_robin();
        test_grant_and_credit();
        test_credit_overflow();
        test_fifo_full();
        test_reset_mid_packet();
        test_stats();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
